// File: rtl/output_transform_unit_pkg.sv
// Shared Winograd F(4x4,3x3) constants and the output-transform state enum.
package winograd_pkg;

    localparam int TILE_IN_SIZE  = 6;
    localparam int TILE_OUT_SIZE = 4;
    localparam int KERNEL_SIZE   = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_PASS = 2'd1,
        COL_PASS = 2'd2
    } otu_state_t;

endpackage

// File: rtl/output_transform_unit_if.sv
// Tile handshake bundle between a requester (master) and the output transform unit (slave).
interface output_transform_unit_if
    import winograd_pkg::*;
#(
    parameter int DATA_WIDTH = 16
);

    logic                                                      start;
    logic [0:TILE_IN_SIZE-1][0:TILE_IN_SIZE-1][DATA_WIDTH-1:0]   tile_in;
    logic [0:TILE_OUT_SIZE-1][0:TILE_OUT_SIZE-1][DATA_WIDTH-1:0] tile_out;
    logic                                                      transform_done;
    logic                                                      busy;

    modport master (
        output start, tile_in,
        input  tile_out, transform_done, busy
    );

    modport slave (
        input  start, tile_in,
        output tile_out, transform_done, busy
    );

endinterface

// File: rtl/output_transform_unit_vec_combine.sv
// Combinational A^T vector combiner: six inputs to four outputs using adds and shifts only.
module otu_vec_combine #(
    parameter int W = 26
) (
    input  logic signed [W-1:0] i_x [0:5],
    output logic signed [W-1:0] o_y [0:3]
);

    logic signed [W-1:0] w_d12, w_s12, w_d34, w_s34;

    // Shared pair sums/differences; rows 1..3 only differ in the shift applied to x3/x4.
    assign w_d12 = i_x[1] - i_x[2];
    assign w_s12 = i_x[1] + i_x[2];
    assign w_d34 = i_x[3] - i_x[4];
    assign w_s34 = i_x[3] + i_x[4];

    assign o_y[0] = i_x[0] + i_x[1] + i_x[2] + i_x[3] + i_x[4];
    assign o_y[1] = w_d12 + (w_d34 <<< 1);
    assign o_y[2] = w_s12 + (w_s34 <<< 2);
    assign o_y[3] = w_d12 + (w_d34 <<< 3) + i_x[5];

endmodule

// File: rtl/output_transform_unit.sv
// Winograd output transform Y = A^T M A over two passes sharing one combiner.
// Define OTU_SATURATE_EN to clamp results instead of wrapping them to DATA_WIDTH.
module output_transform_unit
    import winograd_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output_transform_unit_if.slave  bus
);

    localparam int TW = DATA_WIDTH + 5;
    localparam int YW = DATA_WIDTH + 10;

    otu_state_t r_state, w_nextState;
    logic [3:0] r_cnt;
    logic [0:TILE_IN_SIZE-1][0:TILE_IN_SIZE-1][DATA_WIDTH-1:0]   r_m;
    logic [0:TILE_OUT_SIZE-1][0:TILE_IN_SIZE-1][TW-1:0]          r_t;
    logic [0:TILE_OUT_SIZE-2][0:TILE_OUT_SIZE-1][DATA_WIDTH-1:0] r_yBuf;
    logic [0:TILE_OUT_SIZE-1][0:TILE_OUT_SIZE-1][DATA_WIDTH-1:0] r_tileOut;
    logic r_done;

    logic [2:0] w_colIdx;
    logic [1:0] w_rowIdx;
    logic signed [YW-1:0] w_vecIn  [0:5];
    logic signed [YW-1:0] w_vecOut [0:3];
    logic [DATA_WIDTH-1:0] w_yNarrow [0:3];

    assign w_colIdx = r_cnt[2:0];
    assign w_rowIdx = r_cnt[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (bus.start)      w_nextState = ROW_PASS;
            ROW_PASS: if (r_cnt == 4'd5)  w_nextState = COL_PASS;
            COL_PASS: if (r_cnt == 4'd3)  w_nextState = IDLE;
            default:                      w_nextState = IDLE;
        endcase
    end

    // Row pass feeds a column of the captured tile; column pass feeds a row of T.
    always_comb begin
        for (int k = 0; k < TILE_IN_SIZE; k++) begin
            w_vecIn[k] = '0;
            if (r_state == ROW_PASS)
                w_vecIn[k] = YW'($signed(r_m[k][w_colIdx]));
            else if (r_state == COL_PASS)
                w_vecIn[k] = YW'($signed(r_t[w_rowIdx][k]));
        end
    end

    otu_vec_combine #(.W(YW)) u_combine (
        .i_x (w_vecIn),
        .o_y (w_vecOut)
    );

`ifdef OTU_SATURATE_EN
    localparam logic signed [YW-1:0] Y_MAX = {{(YW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [YW-1:0] Y_MIN = {{(YW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        for (int c = 0; c < TILE_OUT_SIZE; c++) begin
            w_yNarrow[c] = w_vecOut[c][DATA_WIDTH-1:0];
            if (w_vecOut[c] > Y_MAX)      w_yNarrow[c] = Y_MAX[DATA_WIDTH-1:0];
            else if (w_vecOut[c] < Y_MIN) w_yNarrow[c] = Y_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        for (int c = 0; c < TILE_OUT_SIZE; c++)
            w_yNarrow[c] = w_vecOut[c][DATA_WIDTH-1:0];
    end
`endif

    // Rows 0..2 park in a buffer so tile_out only ever changes with a complete result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_m       <= '0;
            r_t       <= '0;
            r_yBuf    <= '0;
            r_tileOut <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_m   <= bus.tile_in;
                        r_cnt <= '0;
                    end
                end
                ROW_PASS: begin
                    for (int j = 0; j < TILE_OUT_SIZE; j++)
                        r_t[j][w_colIdx] <= TW'(w_vecOut[j]);
                    r_cnt <= (r_cnt == 4'd5) ? 4'd0 : r_cnt + 4'd1;
                end
                COL_PASS: begin
                    if (r_cnt == 4'd3) begin
                        for (int i = 0; i < TILE_OUT_SIZE - 1; i++)
                            r_tileOut[i] <= r_yBuf[i];
                        for (int c = 0; c < TILE_OUT_SIZE; c++)
                            r_tileOut[TILE_OUT_SIZE-1][c] <= w_yNarrow[c];
                        r_done <= 1'b1;
                        r_cnt  <= '0;
                    end else begin
                        for (int c = 0; c < TILE_OUT_SIZE; c++)
                            r_yBuf[w_rowIdx][c] <= w_yNarrow[c];
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.tile_out       = r_tileOut;
    assign bus.transform_done = r_done;
    assign bus.busy           = (r_state != IDLE);

endmodule

// File: tb/tb_output_transform_unit.sv
// Scoreboard bench for output_transform_unit; honours OTU_SATURATE_EN when expecting narrowed values.
module tb_output_transform_unit;

    typedef logic [0:5][0:5][15:0] tin_t;
    typedef logic [0:3][0:3][15:0] tout_t;

    typedef struct {
        tout_t tile;
        int    doneCyc;
        string name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t sbQ[$];

    // Hand-entered columns of A^T: atCol[k][r] = A^T[r][k]; rowSum[r] = sum of A^T row r.
    int atCol [0:5][0:3] = '{'{1, 0, 0, 0}, '{1, 1, 1, 1}, '{1, -1, 1, -1},
                             '{1, 2, 4, 8}, '{1, -2, 4, -8}, '{0, 0, 0, 1}};
    int rowSum [0:3] = '{5, 0, 10, 1};

    output_transform_unit_if #(.DATA_WIDTH(16)) bus ();

    output_transform_unit #(.DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint narrowExp(longint v);
        longint w;
`ifdef OTU_SATURATE_EN
        w = v;
        if (w > 32767)  w = 32767;
        if (w < -32768) w = -32768;
`else
        w = v & 64'hFFFF;
        if (w >= 32768) w = w - 65536;
`endif
        return w;
    endfunction

    function automatic tin_t uniformTile(logic [15:0] v);
        tin_t t;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                t[r][c] = v;
        return t;
    endfunction

    function automatic tin_t impulseTile(int pr, int pc, logic [15:0] v);
        tin_t t;
        t = '0;
        t[pr][pc] = v;
        return t;
    endfunction

    function automatic tout_t uniformExp(longint v);
        tout_t y;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                y[i][j] = 16'(narrowExp(v * rowSum[i] * rowSum[j]));
        return y;
    endfunction

    function automatic tout_t impulseExp(int pr, int pc, longint v);
        tout_t y;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                y[i][j] = 16'(narrowExp(v * atCol[pr][i] * atCol[pc][j]));
        return y;
    endfunction

    task automatic checkOutput(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic checkTile(input string name, input tout_t req);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                checkOutput($sformatf("%s Y[%0d][%0d]", name, i, j),
                            64'($signed(bus.tile_out[i][j])), 64'($signed(req[i][j])));
    endtask

    // Issue one start with the given tile on the next edge; scramble tile_in right after capture.
    task automatic applyStimulus(input tin_t m, input tout_t req, input string name, input bit doPush);
        exp_t e;
        @(negedge clk);
        bus.tile_in = m;
        bus.start   = 1'b1;
        if (doPush) begin
            e.tile    = req;
            e.doneCyc = cyc + 1 + 10;
            e.name    = name;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.tile_in = uniformTile(16'h5A5A);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout: %0d results still pending, expected 0", sbQ.size());
            sbQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation, in value and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.transform_done === 1'b1) begin
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected done: got done at cycle %0d expected none", cyc);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({e.name, " done cycle"}, 64'(cyc), 64'(e.doneCyc));
                    checkOutput({e.name, " busy at done"}, 64'(bus.busy), 64'd0);
                    checkTile(e.name, e.tile);
                end
            end
        end
    end

    initial begin
        tin_t seqTiles [0:2];
        tout_t seqExp  [0:2];
        int accIdx;
        exp_t e;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start   = 1'b0;
        bus.tile_in = '0;

        $display("[TB] reset phase");
        repeat (5) begin
            @(negedge clk);
            checkOutput("reset tile_out[0][0]", 64'($signed(bus.tile_out[0][0])), 64'd0);
            checkOutput("reset done", 64'(bus.transform_done), 64'd0);
            checkOutput("reset busy", 64'(bus.busy), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkTile("post-reset", '0);
        checkOutput("post-reset busy", 64'(bus.busy), 64'd0);

        $display("[TB] single tiles");
        applyStimulus(uniformTile(16'd1), uniformExp(1), "ones", 1'b1);
        checkOutput("busy after start", 64'(bus.busy), 64'd1);
        waitIdle();
        applyStimulus(impulseTile(0, 0, 16'd7), impulseExp(0, 0, 7), "imp00", 1'b1);
        waitIdle();
        applyStimulus(impulseTile(5, 5, 16'd3), impulseExp(5, 5, 3), "imp55", 1'b1);
        waitIdle();
        applyStimulus(impulseTile(4, 3, 16'd1), impulseExp(4, 3, 1), "imp43", 1'b1);
        waitIdle();
        applyStimulus(impulseTile(1, 2, 16'd2), impulseExp(1, 2, 2), "imp12", 1'b1);
        waitIdle();

        repeat (5) @(negedge clk);
        checkTile("hold", impulseExp(1, 2, 2));

        $display("[TB] large values");
        applyStimulus(uniformTile(16'd30000), uniformExp(30000), "pos30000", 1'b1);
        waitIdle();
        applyStimulus(uniformTile(-16'sd30000), uniformExp(-30000), "neg30000", 1'b1);
        waitIdle();

        $display("[TB] start held high");
        seqTiles[0] = uniformTile(16'd1);        seqExp[0] = uniformExp(1);
        seqTiles[1] = impulseTile(0, 0, 16'd7);  seqExp[1] = impulseExp(0, 0, 7);
        seqTiles[2] = impulseTile(5, 5, 16'd3);  seqExp[2] = impulseExp(5, 5, 3);
        accIdx = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            bus.start = 1'b1;
            if (k == 0 || k == 11 || k == 22) begin
                bus.tile_in = seqTiles[accIdx];
                e.tile    = seqExp[accIdx];
                e.doneCyc = cyc + 1 + 10;
                e.name    = $sformatf("held%0d", accIdx);
                sbQ.push_back(e);
                accIdx++;
            end else begin
                bus.tile_in = uniformTile(16'(k * 37));
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle();

        $display("[TB] start pulse while busy");
        applyStimulus(uniformTile(16'd2), uniformExp(2), "twos", 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.tile_in = uniformTile(16'd100);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        waitIdle();
        repeat (12) @(negedge clk);
        checkOutput("idle after ignored start", 64'(bus.busy), 64'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(uniformTile(16'd3), uniformExp(3), "aborted", 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkTile("abort", '0);
        checkOutput("abort done", 64'(bus.transform_done), 64'd0);
        checkOutput("abort busy", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        applyStimulus(impulseTile(4, 3, 16'd1), impulseExp(4, 3, 1), "after-abort", 1'b1);
        waitIdle();

        checkOutput("pending at end", 64'(sbQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/output_transform_unit.md
OUTPUT_TRANSFORM_UNIT -- requirements
Module: output_transform_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of signed two's-complement input and output elements.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to transform the tile on tile_in; sampled only in IDLE.
REQ-005 tile_in  input  [0:5][0:5] x DATA_WIDTH  6x6 Winograd-domain product tile M, signed.
REQ-006 tile_out  output  [0:3][0:3] x DATA_WIDTH  4x4 spatial result Y = A^T M A, signed, registered.
REQ-007 transform_done  output  1  one-cycle pulse; tile_out valid from that cycle onward.
REQ-008 busy  output  1  high in every non-IDLE state.

Function
REQ-009 A^T SHALL be F(4x4,3x3): rows [1 1 1 1 1 0], [0 1 -1 2 -2 0], [0 1 1 4 4 0], [0 1 -1 8 -8 1]; multiplies by 2/4/8 as shifts, no hardware multipliers.
REQ-010 States IDLE, ROW_PASS, COL_PASS; 4-bit index counter.
REQ-011 IDLE with start=1 at edge k: capture all 36 tile_in elements, counter=0, go ROW_PASS; start=0 keeps IDLE.
REQ-012 ROW_PASS: at edges k+1..k+6 compute column j=counter of T = A^T M (4 values) into intermediate register; after j=5 go COL_PASS, counter=0.
REQ-013 COL_PASS: at edges k+7..k+10 compute row i=counter of Y = T A (4 values) into result buffer.
REQ-014 At edge k+10 tile_out SHALL be loaded with all 16 results at once, transform_done=1, state to IDLE; latency 10 cycles start-edge to done.
REQ-015 tile_out SHALL hold its value between completions; it never shows partial results.
REQ-016 transform_done SHALL be high exactly one cycle per accepted start.
REQ-017 start while busy SHALL be ignored (not queued); start in the done cycle (IDLE) SHALL be accepted, giving back-to-back throughput of one tile per 11 cycles.
REQ-018 tile_in changes after the capture edge SHALL NOT affect the result.
REQ-019 Intermediate T width DATA_WIDTH+5, Y accumulation width DATA_WIDTH+10, full sign extension; no loss before final narrowing.
REQ-020 Final narrowing to DATA_WIDTH per Configuration.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, counter=0, tile_out all zero, transform_done=0, busy=0, capture/intermediate registers zero.
REQ-022 Reset mid-operation SHALL abort the tile; no transform_done is produced for it.
REQ-023 First start accepted only at a rising edge with rst_n already high.

Configuration
REQ-024 Macro OTU_SATURATE_EN defined: each Y element clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-025 Macro OTU_SATURATE_EN undefined: each Y element SHALL be its low DATA_WIDTH bits (wrap-around).

Structure
REQ-026 Shared package winograd_pkg SHALL hold TILE_IN_SIZE=6, TILE_OUT_SIZE=4, KERNEL_SIZE=3, and the state enum otu_state_t.
REQ-027 One sub-module otu_vec_combine: combinational 6-in/4-out A^T vector combiner, parameterized width, instantiated once at DATA_WIDTH+10 and shared by both passes via input mux.

Verification
REQ-028 Reset held 5 cycles, then released -> tile_out all 0, transform_done 0, busy 0 throughout.
REQ-029 tile_in all 1, single start -> done exactly 10 cycles after start edge; rows [25 0 50 5], [0 0 0 0], [50 0 100 10], [5 0 10 1].
REQ-030 Impulse M[0][0]=7 -> Y[0][0]=7, others 0; impulse M[5][5]=3 -> Y[3][3]=3, others 0.
REQ-031 tile_in all 30000 with OTU_SATURATE_EN -> Y[0][0]=32767, Y[2][2]=32767, Y[1][*]=0; all -30000 -> Y[0][0]=-32768; without macro, all 30000 -> Y[0][0]=750000 mod 2^16 as signed (29104).
REQ-032 start held high 30 cycles -> exactly one done per 11 cycles; start pulse in mid-ROW_PASS ignored.
REQ-033 rst_n asserted at cycle 4 after start -> outputs zero at once, no done pulse; fresh start afterwards gives correct result.
